// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data memory, with halt-drain support.
// Define ARB_STARVE_GUARD_EN to bound consecutive data grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [1:0]    dm_size,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  input  logic          halt,
  output logic          quiesced,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_size,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, RESP} state_t;

  state_t state;
  logic   if_ok;
  logic   pick_if;

  assign if_ok    = if_req & ~halt;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  assign quiesced = halt & (state == IDLE);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 2);

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_LIMIT));
  assign pick_if = if_ok & (~dm_req | starved);

  // Counts data grants that overtook a live fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_if)
        starve_cnt <= '0;
      else if (dm_req && if_ok && !starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // The limit only matters with the guard; without it data always wins.
  localparam bit LIMIT_OK = (STARVE_LIMIT >= 0);

  assign pick_if = if_ok & ~dm_req & LIMIT_OK;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 2'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_size  <= 2'd2;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= BUSY_IF;
          end else if (dm_req) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_size  <= dm_size;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= BUSY_DM;
          end
        end
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        BUSY_DM: begin
          // Stores capture the read bus too; the requester ignores it.
          if (mem_ready) begin
            dm_rdata <= mem_rdata;
            dm_done  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= RESP;
          end
        end
        default: begin
          if_done <= 1'b0;
          dm_done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter; read-data expectations go through per-requester queues.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst, if_req, dm_req, dm_we, halt, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [1:0] dm_size;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [1:0] mem_size;
  logic if_done, if_stall, dm_done, dm_stall, quiesced, mem_req, mem_we;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .halt(halt), .quiesced(quiesced),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; halt = 1'b0; mem_ready = 1'b1;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_size = 2'd0; mem_rdata = 32'h1234_5678;
    tick(); tick();
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if ({mem_we, mem_size} !== 3'b000) begin n_bad++; $display("FAIL reset_we_size got %b want 000", {mem_we, mem_size}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 64'h0) begin n_bad++; $display("FAIL reset_addr_wdata got %h want 0", {mem_addr, mem_wdata}); end
    n_cmp++; if ({if_done, dm_done} !== 2'b00) begin n_bad++; $display("FAIL reset_done got %b want 00", {if_done, dm_done}); end
    n_cmp++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", {if_rdata, dm_rdata}); end
    halt = 1'b1; #1;
    n_cmp++; if (quiesced !== 1'b1) begin n_bad++; $display("FAIL reset_quiesced got %b want 1", quiesced); end
    halt = 1'b0; rst = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    if_q.push_back(32'h0050_0093);
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_size} !== 4'b1010) begin n_bad++; $display("FAIL fetch_ctrl got %b want 1010", {mem_req, mem_we, mem_size}); end
    n_cmp++; if (mem_addr !== 32'h40) begin n_bad++; $display("FAIL fetch_addr got %h want 40", mem_addr); end
    n_cmp++; if ({if_done, if_stall} !== 2'b01) begin n_bad++; $display("FAIL fetch_busy_done_stall got %b want 01", {if_done, if_stall}); end
    tick();
    n_cmp++; if ({if_done, if_stall, mem_req} !== 3'b100) begin n_bad++; $display("FAIL fetch_resp got %b want 100", {if_done, if_stall, mem_req}); end
    if (if_done === 1'b1) begin
      n_cmp++;
      if (if_q.size() == 0) begin n_bad++; $display("FAIL fetch_rdata got done with empty queue"); end
      else begin
        logic [DW-1:0] e = if_q.pop_front();
        if (if_rdata !== e) begin n_bad++; $display("FAIL fetch_rdata got %h want %h", if_rdata, e); end
      end
    end
    if_req = 1'b0;
    tick();
    n_cmp++; if ({mem_req, if_done} !== 2'b00) begin n_bad++; $display("FAIL fetch_idle got %b want 00", {mem_req, if_done}); end
    n_cmp++; if (if_rdata !== 32'h0050_0093) begin n_bad++; $display("FAIL fetch_rdata_hold got %h want 00500093", if_rdata); end
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'd2; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_size} !== 4'b1110) begin n_bad++; $display("FAIL sim_dm_ctrl got %b want 1110", {mem_req, mem_we, mem_size}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin n_bad++; $display("FAIL sim_dm_fields got %h want 00000100deadbeef", {mem_addr, mem_wdata}); end
    n_cmp++; if ({if_stall, dm_stall} !== 2'b11) begin n_bad++; $display("FAIL sim_stalls_c2 got %b want 11", {if_stall, dm_stall}); end
    tick();
    n_cmp++; if ({dm_done, dm_stall, if_stall, mem_req} !== 4'b1010) begin n_bad++; $display("FAIL sim_dm_done got %b want 1010", {dm_done, dm_stall, if_stall, mem_req}); end
    n_cmp++; if (dm_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL sim_store_capture got %h want 11111111", dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'h2222_2222;
    if_q.push_back(32'h2222_2222);
    tick();
    n_cmp++; if ({mem_req, if_stall} !== 2'b01) begin n_bad++; $display("FAIL sim_idle_c4 got %b want 01", {mem_req, if_stall}); end
    tick();
    n_cmp++; if ({mem_req, mem_we, mem_size, if_stall} !== 5'b10101) begin n_bad++; $display("FAIL sim_if_grant got %b want 10101", {mem_req, mem_we, mem_size, if_stall}); end
    n_cmp++; if (mem_addr !== 32'h80) begin n_bad++; $display("FAIL sim_if_addr got %h want 80", mem_addr); end
    tick();
    n_cmp++; if ({if_done, if_stall} !== 2'b10) begin n_bad++; $display("FAIL sim_if_done got %b want 10", {if_done, if_stall}); end
    if (if_done === 1'b1) begin
      n_cmp++;
      if (if_q.size() == 0) begin n_bad++; $display("FAIL sim_if_rdata got done with empty queue"); end
      else begin
        logic [DW-1:0] e = if_q.pop_front();
        if (if_rdata !== e) begin n_bad++; $display("FAIL sim_if_rdata got %h want %h", if_rdata, e); end
      end
    end
    if_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_wait_states();
    int dones = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd1; dm_addr = 32'h200; dm_wdata = 32'h5555_AAAA;
    mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D;
    dm_q.push_back(32'hCAFE_F00D);
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({mem_req, mem_we, mem_size, mem_addr, dm_stall, dm_done} !== {4'b1001, 32'h200, 2'b10}) begin
        n_bad++; $display("FAIL wait_hold_%0d got %b/%h/%b want 1001/00000200/10", i, {mem_req, mem_we, mem_size}, mem_addr, {dm_stall, dm_done});
      end
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    if (dm_done === 1'b1) begin
      dones++;
      n_cmp++;
      if (dm_q.size() == 0) begin n_bad++; $display("FAIL wait_rdata got done with empty queue"); end
      else begin
        logic [DW-1:0] e = dm_q.pop_front();
        if (dm_rdata !== e) begin n_bad++; $display("FAIL wait_rdata got %h want %h", dm_rdata, e); end
      end
    end
    n_cmp++; if (dm_stall !== 1'b0) begin n_bad++; $display("FAIL wait_stall_at_done got %b want 0", dm_stall); end
    dm_req = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (dm_done === 1'b1) dones++;
    end
    n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL wait_done_count got %0d want 1", dones); end
    mem_ready = 1'b1;
  endtask

  task automatic test_starvation();
    int grants = 0;
    int cnt = 0;
    int cyc = 0;
    logic prev = 1'b0;
    logic exp_if;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h90; mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
    while (grants < 20 && cyc < 200) begin
      tick(); cyc++;
      if (mem_req === 1'b1 && prev === 1'b0) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_if = (cnt == LIMIT);
        cnt = exp_if ? 0 : cnt + 1;
`else
        exp_if = 1'b0;
        cnt = cnt + 1;
`endif
        n_cmp++;
        if (mem_addr !== (exp_if ? 32'h90 : 32'h300)) begin
          n_bad++; $display("FAIL starve_grant_%0d got addr %h want %h", grants, mem_addr, exp_if ? 32'h90 : 32'h300);
        end
        grants++;
      end
      prev = mem_req;
    end
    n_cmp++; if (grants != 20) begin n_bad++; $display("FAIL starve_bound got %0d grants want 20", grants); end
    cyc = 0;
    while (!(if_done === 1'b1 || dm_done === 1'b1) && cyc < 20) begin tick(); cyc++; end
    dm_req = 1'b0; if_req = 1'b0;
    tick(); tick();
  endtask

  task automatic test_halt_drain();
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd0; dm_addr = 32'h400;
    if_req = 1'b1; if_addr = 32'hA0; mem_ready = 1'b0; mem_rdata = 32'h7777_0001;
    dm_q.push_back(32'h7777_0001);
    tick();
    n_cmp++; if ({mem_req, mem_addr} !== {1'b1, 32'h400}) begin n_bad++; $display("FAIL halt_dm_grant got %b/%h want 1/00000400", mem_req, mem_addr); end
    halt = 1'b1; #1;
    n_cmp++; if (quiesced !== 1'b0) begin n_bad++; $display("FAIL halt_busy_quiesced got %b want 0", quiesced); end
    tick();
    mem_ready = 1'b1;
    tick();
    n_cmp++; if ({dm_done, quiesced} !== 2'b10) begin n_bad++; $display("FAIL halt_dm_done got %b want 10", {dm_done, quiesced}); end
    if (dm_done === 1'b1) begin
      n_cmp++;
      if (dm_q.size() == 0) begin n_bad++; $display("FAIL halt_rdata got done with empty queue"); end
      else begin
        logic [DW-1:0] e = dm_q.pop_front();
        if (dm_rdata !== e) begin n_bad++; $display("FAIL halt_rdata got %h want %h", dm_rdata, e); end
      end
    end
    dm_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({quiesced, mem_req, if_done, if_stall} !== 4'b1001) begin
        n_bad++; $display("FAIL halt_idle_%0d got %b want 1001", i, {quiesced, mem_req, if_done, if_stall});
      end
    end
    halt = 1'b0; if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_transfer();
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h500;
    mem_ready = 1'b0; mem_rdata = 32'h9999_9999;
    tick();
    n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant got %b want 1", mem_req); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({mem_req, dm_done} !== 2'b00) begin n_bad++; $display("FAIL rstmid_ctrl got %b want 00", {mem_req, dm_done}); end
    n_cmp++; if (dm_rdata !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata got %h want 0", dm_rdata); end
    rst = 1'b1; dm_req = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if ({mem_req, dm_done, if_done} !== 3'b000) begin
        n_bad++; $display("FAIL rstmid_after_%0d got %b want 000", i, {mem_req, dm_done, if_done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_wait_states();
    test_starvation();
    test_halt_drain();
    test_reset_mid_transfer();
    n_cmp++;
    if (if_q.size() != 0 || dm_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain got %0d/%0d left want 0/0", if_q.size(), dm_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
